// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: pixel divider, x/y counters, sync and blanking
// Optional macro VGA_PIPE_ALIGN_EN delays HS/VS/BLANK_N by one pixel to match RGB-path read latency.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       active,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
  localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          tick;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          act_nxt;
  logic          hs_q;
  logic          vs_q;

  always_comb begin
    tick      = (phase == PH_LAST);
    phase_nxt = tick ? '0 : phase + PW'(1);
    x_nxt     = x;
    y_nxt     = y;
    if (tick) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? 10'd0 : y + 10'd1;
      end else begin
        x_nxt = x + 10'd1;
      end
    end
    // Decoded from the next counter values so registered outputs line up with x/y
    hs_nxt  = (({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END)) ? HS_ON : ~HS_ON;
    vs_nxt  = (({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END)) ? VS_ON : ~VS_ON;
    act_nxt = ({1'b0, x_nxt} < H_ACT) && ({1'b0, y_nxt} < V_ACT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase       <= '0;
      x           <= '0;
      y           <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      active      <= 1'b1;
      hs_q        <= ~HS_ON;
      vs_q        <= ~VS_ON;
      VGA_CLK     <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      pix_tick    <= (phase_nxt == PH_LAST);
      frame_start <= tick && (x_nxt == 10'd0) && (y_nxt == 10'd0);
      active      <= act_nxt;
      hs_q        <= hs_nxt;
      vs_q        <= vs_nxt;
      VGA_CLK     <= (phase_nxt >= PH_HALF);
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_d;
  logic vs_d;
  logic blank_d;

  // Captures the pre-advance values on each pixel edge, i.e. the previous pixel
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_d    <= ~HS_ON;
      vs_d    <= ~VS_ON;
      blank_d <= 1'b0;
    end else if (tick) begin
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      blank_d <= active;
    end
  end

  assign VGA_HS      = hs_d;
  assign VGA_VS      = vs_d;
  assign VGA_BLANK_N = blank_d;
`else
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = active;
`endif

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default 640x480 instance plus a tiny-raster instance for frame-level timing
// Honours VGA_PIPE_ALIGN_EN when the bench is built with the same macro as the RTL.
module tb_vga_timing_gen;

`ifdef VGA_PIPE_ALIGN_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rst_b;
  logic [9:0] xa, ya, xb, yb;
  logic       ta, aa, fa, ca, hsa, vsa, bna, sna;
  logic       tb, ab, fb, cb, hsb, vsb, bnb, snb;

  int total = 0;
  int bad   = 0;

  vga_timing_gen u_a (
    .CLK(clk), .RST(rst_a), .x(xa), .y(ya), .pix_tick(ta), .active(aa),
    .frame_start(fa), .VGA_CLK(ca), .VGA_HS(hsa), .VGA_VS(vsa),
    .VGA_BLANK_N(bna), .VGA_SYNC_N(sna)
  );

  // 15x8 raster, divide-by-3, positive HS: a whole frame is 360 CLK
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(0)
  ) u_b (
    .CLK(clk), .RST(rst_b), .x(xb), .y(yb), .pix_tick(tb), .active(ab),
    .frame_start(fb), .VGA_CLK(cb), .VGA_HS(hsb), .VGA_VS(vsb),
    .VGA_BLANK_N(bnb), .VGA_SYNC_N(snb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = number of edges since the last edge that sampled RST high
  task automatic cmp(input string d, input int n, input int div, input int ht, input int vt,
                     input int ha, input int va, input int hs0, input int hs1,
                     input int vs0, input int vs1, input int hp, input int vp,
                     input logic [9:0] ox, input logic [9:0] oy, input logic ot,
                     input logic oa, input logic of, input logic oc, input logic oh,
                     input logic ov, input logic ob, input logic osn);
    int p, ph, ex, ey, q, qx, qy, eh, ev, eb;
    p  = n / div;
    ph = n % div;
    ex = p % ht;
    ey = (p / ht) % vt;
    q  = p - PIPE;
    if (q < 0) begin
      eh = 1 - hp;
      ev = 1 - vp;
      eb = 0;
    end else begin
      qx = q % ht;
      qy = (q / ht) % vt;
      eh = (qx >= hs0 && qx < hs1) ? hp : 1 - hp;
      ev = (qy >= vs0 && qy < vs1) ? vp : 1 - vp;
      eb = (qx < ha && qy < va) ? 1 : 0;
    end
    chk($sformatf("%s x n=%0d", d, n), 32'(ox), ex);
    chk($sformatf("%s y n=%0d", d, n), 32'(oy), ey);
    chk($sformatf("%s pix_tick n=%0d", d, n), 32'(ot), (ph == div - 1) ? 1 : 0);
    chk($sformatf("%s vga_clk n=%0d", d, n), 32'(oc), (ph >= div / 2) ? 1 : 0);
    chk($sformatf("%s active n=%0d", d, n), 32'(oa), (ex < ha && ey < va) ? 1 : 0);
    chk($sformatf("%s frame_start n=%0d", d, n), 32'(of), (n > 0 && n % (div * ht * vt) == 0) ? 1 : 0);
    chk($sformatf("%s hs n=%0d", d, n), 32'(oh), eh);
    chk($sformatf("%s vs n=%0d", d, n), 32'(ov), ev);
    chk($sformatf("%s blank_n n=%0d", d, n), 32'(ob), eb);
    chk($sformatf("%s sync_n n=%0d", d, n), 32'(osn), 0);
  endtask

  task automatic chk_a(input int n);
    cmp("A", n, 2, 800, 525, 640, 480, 656, 752, 490, 492, 0, 0,
        xa, ya, ta, aa, fa, ca, hsa, vsa, bna, sna);
  endtask

  task automatic chk_b(input int n);
    cmp("B", n, 3, 15, 8, 8, 4, 10, 13, 5, 7, 1, 0,
        xb, yb, tb, ab, fb, cb, hsb, vsb, bnb, snb);
  endtask

  initial begin
    int hs_low, bl_low, first_hs, first_bl, fs_cnt, fs_at, act_ticks;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Default instance: reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a(0);
    end
    chk("A reset hs", 32'(hsa), 1);
    chk("A reset vs", 32'(vsa), 1);
    rst_a = 1'b0;

    hs_low = 0; bl_low = 0; first_hs = -1; first_bl = -1;
    for (int n = 1; n <= 1610; n++) begin
      step();
      chk_a(n);
      if (n == 2) chk("A first tick x", 32'(xa), 1);
      if (n == 1600) begin
        chk("A line wrap y", 32'(ya), 1);
        chk("A line wrap x", 32'(xa), 0);
      end
      if (n >= 2 && n < 1602) begin
        if (hsa == 1'b0) begin
          hs_low++;
          if (first_hs < 0) first_hs = n;
        end
        if (bna == 1'b0) begin
          bl_low++;
          if (first_bl < 0) first_bl = n;
        end
      end
    end
    chk("A hs low cycles", hs_low, 192);
    chk("A blank low cycles", bl_low, 320);
    chk("A hs first low", first_hs, 1312 + 2 * PIPE);
    chk("A blank first low", first_bl, 1280 + 2 * PIPE);

    // Small instance: two-frame run up to x=12,y=5 of frame 1
    chk_b(0);
    rst_b = 1'b0;
    fs_cnt = 0; fs_at = -1; act_ticks = 0;
    for (int n = 1; n <= 621; n++) begin
      step();
      chk_b(n);
      if (fb) begin
        fs_cnt++;
        fs_at = n;
      end
      if (n < 360 && tb && ab) act_ticks++;
      if (n == 360) begin
        chk("B corner x", 32'(xb), 0);
        chk("B corner y", 32'(yb), 0);
        chk("B corner fs", 32'(fb), 1);
        chk("B corner active", 32'(ab), 1);
        chk("B corner vs", 32'(vsb), 1);
        chk("B corner hs", 32'(hsb), 0);
      end
    end
    chk("B frame_start count", fs_cnt, 1);
    chk("B frame_start at", fs_at, 360);
    chk("B active ticks", act_ticks, 32);
    chk("B pre-reset x", 32'(xb), 12);
    chk("B pre-reset hs", 32'(hsb), 1);
    chk("B pre-reset vs", 32'(vsb), 0);

    // Mid-frame reset
    rst_b = 1'b1;
    step();
    chk_b(0);
    chk("B reset x", 32'(xb), 0);
    chk("B reset hs", 32'(hsb), 0);
    chk("B reset vs", 32'(vsb), 1);
    rst_b = 1'b0;

    first_hs = -1; fs_at = -1;
    for (int n = 1; n <= 400; n++) begin
      step();
      chk_b(n);
      if (hsb && first_hs < 0) first_hs = n;
      if (fb && fs_at < 0) fs_at = n;
    end
    chk("B hs first after reset", first_hs, 30 + 3 * PIPE);
    chk("B frame_start after reset", fs_at, 360);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: pixel counters x/y, sync pulses and blanking.
- Sits upstream of video_controller, which consumes x/y, returns RGB, and drives the DAC.
- Runs from the 50 MHz board clock with an internal pixel-enable divider.
- Default mode is 640x480@60 Hz (25 MHz pixel rate).

Parameters:
- CLK_DIV, 2: board CLK cycles per pixel (>=2).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: horizontal sync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vertical sync width (lines).
- V_BP, 33: vertical back porch (lines).
- HS_POL, 0: active level of VGA_HS.
- VS_POL, 0: active level of VGA_VS.

Ports:
- CLK  in  1  board clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- x  out  10  current pixel column, 0..H_TOTAL-1.
- y  out  10  current line, 0..V_TOTAL-1.
- pix_tick  out  1  one-CLK pulse on the edge that advances x.
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE.
- frame_start  out  1  one-CLK pulse when the counters enter (0,0).
- VGA_CLK  out  1  pixel clock to DAC, CLK/CLK_DIV.
- VGA_HS  out  1  horizontal sync.
- VGA_VS  out  1  vertical sync.
- VGA_BLANK_N  out  1  low outside the active region.
- VGA_SYNC_N  out  1  constant 0 (sync-on-green unused).

Behaviour:
- H_TOTAL = sum of the four H params (800). V_TOTAL = sum of the four V params (525). Counter width is fixed at 10 bits; totals must be <=1024.
- Divider: phase counts 0..CLK_DIV-1, then wraps. pix_tick=1 on the CLK cycle where phase==CLK_DIV-1; x/y update on that same edge.
- VGA_CLK is registered and high when phase>=CLK_DIV/2. With CLK_DIV=2 it toggles every CLK.
- Horizontal counter: x increments on each pixel tick. When x==H_TOTAL-1, x wraps to 0.
- Vertical counter: y increments only on the wrap of x. When y==V_TOTAL-1 and x wraps, y wraps to 0.
- All outputs are registered and computed from the next counter value, so HS/VS/BLANK_N/active always describe the x/y presented in the same cycle (zero skew).
- VGA_HS = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
- VGA_VS = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. VS changes only together with an x wrap.
- VGA_BLANK_N = active.
- frame_start = 1 for exactly the CLK cycle following the edge on which x,y became 0,0.
- Reset values: phase=0, x=0, y=0, pix_tick=0, frame_start=0, active=1, VGA_BLANK_N=1, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_CLK=0.
- Reset mid-frame: all state returns to the reset values on the next CLK edge. The next pixel tick occurs CLK_DIV cycles after RST deasserts and moves x to 1.
- Simultaneous x wrap and y wrap: both counters go to 0 on the same edge, and frame_start pulses.
- No other inputs exist; the timing runs free.

Optional Feature:
- VGA_PIPE_ALIGN_EN.
  - Defined: VGA_HS, VGA_VS and VGA_BLANK_N pass through one extra pixel-rate stage, so they lag x/y by exactly one pixel (CLK_DIV CLK cycles). This matches the 1-cycle read latency of the sprite memories in the RGB path.
  - Delay registers reset to the non-asserted sync levels and BLANK_N=0.
  - x, y, active, frame_start and pix_tick are not delayed.
  - Not defined: zero-skew behaviour as specified above.

Test Plan:
- RST held 5 cycles, then released with default params:
  - x=0, y=0, HS=VS=1 while reset is held.
  - First pix_tick 2 CLK after release, x=1.
  - VGA_CLK period is 2 CLK.
- One full line:
  - x counts 0..799 and wraps; y becomes 1 after 1600 CLK.
  - VGA_HS low exactly for x=656..751 (96 pixels).
  - BLANK_N low for x=640..799.
- One full frame:
  - frame_start pulses every 840000 CLK.
  - VGA_VS low exactly for y=490..491 (1600 pixel ticks).
  - active high for 307200 pixel ticks per frame.
- Wrap corner at x=799, y=524: next tick gives x=0, y=0, frame_start=1, active=1, VS high, HS high.
- RST asserted at x=700, y=300:
  - Next CLK gives x=0, y=0, outputs at reset values.
  - After release, HS is next low at x=656 of line 0.
- With VGA_PIPE_ALIGN_EN defined:
  - VGA_HS falls 2 CLK after x becomes 656.
  - BLANK_N falls 2 CLK after x becomes 640.
  - BLANK_N is 0 for the first pixel after reset.
